// File: rtl/branch_predictor_if.sv
// Fetch/EX-side signal bundle for the branch predictor; the pipeline is the
// master, the predictor the slave.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  if_pred_taken;
  logic [DATA_WIDTH-1:0] if_pred_target;
  logic                  ex_branch;
  logic                  ex_stall;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic                  ex_taken;
  logic [DATA_WIDTH-1:0] ex_target;
  logic                  ex_pred_taken;
  logic [DATA_WIDTH-1:0] ex_pred_target;
  logic                  resolve;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [31:0]           br_count;
  logic [31:0]           mispred_count;

  modport master (
    output if_pc, ex_branch, ex_stall, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  if_pred_taken, if_pred_target, resolve, redirect_pc,
           br_count, mispred_count
  );

  modport slave (
    input  if_pc, ex_branch, ex_stall, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_pred_target, resolve, redirect_pc,
           br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: IF-stage lookup,
// EX-stage mispredict detection, table training and branch statistics.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 6
) (
  input logic               clk,
  input logic               rstn,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_W   = DATA_WIDTH - IDX_BITS - 2;

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  word_t             target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [31:0]       br_q;
  logic [31:0]       mis_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]    if_tag;
  logic [TAG_W-1:0]    ex_tag;
  logic                if_hit;
  logic                ex_hit;
  logic                pred_taken;
  logic                mispred;
  logic                upd_en;

  assign if_idx = bus.if_pc[IDX_BITS+1:2];
  assign if_tag = bus.if_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bus.ex_pc[DATA_WIDTH-1:IDX_BITS+2];

  always_comb begin
    if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    pred_taken = if_hit && ctr_q[if_idx][1];
    mispred    = bus.ex_branch &&
                 ((bus.ex_taken != bus.ex_pred_taken) ||
                  (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    upd_en     = bus.ex_branch && !bus.ex_stall;
  end

  assign bus.if_pred_taken  = pred_taken;
  assign bus.if_pred_target = pred_taken ? target_q[if_idx] : bus.if_pc + word_t'(4);
  // Gated with rstn so the hazard unit never sees a flush while in reset.
  assign bus.resolve        = rstn && mispred;
  assign bus.redirect_pc    = bus.ex_taken ? bus.ex_target : bus.ex_pc + word_t'(4);
  assign bus.br_count       = br_q;
  assign bus.mispred_count  = mis_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
      br_q  <= '0;
      mis_q <= '0;
    end else if (upd_en) begin
      if (ex_hit) begin
        if (bus.ex_taken) begin
          if (ctr_q[ex_idx] != 2'd3) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= bus.ex_target;
        end else if (ctr_q[ex_idx] != 2'd0) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (bus.ex_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.ex_target;
        ctr_q[ex_idx]    <= 2'd2;
      end
      if (br_q != '1) br_q <= br_q + 32'd1;
      if (mispred && (mis_q != '1)) mis_q <= mis_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural BTB model.
module tb_branch_predictor;
  localparam int DW  = 32;
  localparam int IB  = 6;
  localparam int ENT = 1 << IB;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  bit   chk_en;

  branch_predictor_if #(.DATA_WIDTH(DW)) bus ();

  branch_predictor #(.DATA_WIDTH(DW), .IDX_BITS(IB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: each slot remembers the full upper-PC tag it holds.
  bit          m_valid  [ENT];
  int unsigned m_tag    [ENT];
  int unsigned m_target [ENT];
  int          m_ctr    [ENT];
  int unsigned m_br;
  int unsigned m_mis;

  function automatic int slot_of(input int unsigned pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENT);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic void model_lookup(input int unsigned pc, output bit pt,
                                       output int unsigned tgt);
    int s;
    s   = slot_of(pc);
    pt  = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    tgt = pt ? m_target[s] : pc + 4;
  endfunction

  function automatic bit model_mispred();
    if (!bus.ex_branch) return 0;
    if (bus.ex_taken != bus.ex_pred_taken) return 1;
    return bus.ex_taken && (bus.ex_target != bus.ex_pred_target);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model training mirrors the architectural update rule.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else if (bus.ex_branch && !bus.ex_stall) begin
      int s;
      bit mp;
      s  = slot_of(bus.ex_pc);
      mp = model_mispred();
      if (m_valid[s] && m_tag[s] == tag_of(bus.ex_pc)) begin
        if (bus.ex_taken) begin
          m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_target[s] = bus.ex_target;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (bus.ex_taken) begin
        m_valid[s]  = 1;
        m_tag[s]    = tag_of(bus.ex_pc);
        m_target[s] = bus.ex_target;
        m_ctr[s]    = 2;
      end
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mp && m_mis != 32'hFFFF_FFFF) m_mis++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit          pt;
      int unsigned tgt;
      model_lookup(bus.if_pc, pt, tgt);
      chk("if_pred_taken", {31'd0, bus.if_pred_taken}, {31'd0, pt});
      chk("if_pred_target", bus.if_pred_target, tgt);
      chk("resolve", {31'd0, bus.resolve}, {31'd0, rstn && model_mispred()});
      chk("redirect_pc", bus.redirect_pc, bus.ex_taken ? bus.ex_target : bus.ex_pc + 4);
      chk("br_count", bus.br_count, m_br);
      chk("mispred_count", bus.mispred_count, m_mis);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit br, input bit stall, input int unsigned pc,
                        input bit tk, input int unsigned tgt,
                        input bit ptk, input int unsigned ptgt);
    bus.ex_branch      = br;
    bus.ex_stall       = stall;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask

  function automatic int unsigned pick_pc();
    return ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 0;
    rstn     = 1'b0;
    model_reset();
    bus.if_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk_en = 1;
    rstn   = 1'b1;
    #2;
    chk("rst_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("rst_pred_target", bus.if_pred_target, 32'h104);
    chk("rst_br_count", bus.br_count, 32'd0);
    chk("rst_mispred_count", bus.mispred_count, 32'd0);

    // Cold miss on a taken branch: mispredict, then allocate weakly taken.
    cyc();
    set_ex(1, 0, 32'h100, 1, 32'h200, 0, 32'h104);
    #2;
    chk("alloc_resolve", {31'd0, bus.resolve}, 32'd1);
    chk("alloc_redirect", bus.redirect_pc, 32'h200);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("alloc_pred_taken", {31'd0, bus.if_pred_taken}, 32'd1);
    chk("alloc_pred_target", bus.if_pred_target, 32'h200);
    chk("alloc_br_count", bus.br_count, 32'd1);
    chk("alloc_mispred_count", bus.mispred_count, 32'd1);

    // Two not-taken resolutions walk the counter 2 -> 1 -> 0.
    cyc();
    set_ex(1, 0, 32'h100, 0, 32'h200, 1, 32'h200);
    #2;
    chk("nt1_resolve", {31'd0, bus.resolve}, 32'd1);
    chk("nt1_redirect", bus.redirect_pc, 32'h104);
    cyc();
    set_ex(1, 0, 32'h100, 0, 32'h200, 0, 32'h104);
    #2;
    chk("nt1_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("nt2_resolve", {31'd0, bus.resolve}, 32'd0);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("nt2_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("nt2_br_count", bus.br_count, 32'd3);
    chk("nt2_mispred_count", bus.mispred_count, 32'd2);

    // Aliasing branch evicts 0x100's entry.
    cyc();
    set_ex(1, 0, 32'h100 + (4 << IB), 1, 32'h300, 0, 32'h204);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    bus.if_pc = 32'h100 + (4 << IB);
    #2;
    chk("alias_pred_taken", {31'd0, bus.if_pred_taken}, 32'd1);
    chk("alias_pred_target", bus.if_pred_target, 32'h300);
    cyc();
    bus.if_pc = 32'h100;
    #2;
    chk("victim_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("victim_pred_target", bus.if_pred_target, 32'h104);

    // Stalled taken branch updates only on its release cycle.
    cyc();
    bus.if_pc = 32'h140;
    set_ex(1, 1, 32'h140, 1, 32'h500, 0, 32'h144);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_resolve", {31'd0, bus.resolve}, 32'd1);
      chk("stall_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
      chk("stall_br_count", bus.br_count, 32'd4);
      cyc();
    end
    bus.ex_stall = 0;
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("release_pred_taken", {31'd0, bus.if_pred_taken}, 32'd1);
    chk("release_pred_target", bus.if_pred_target, 32'h500);
    chk("release_br_count", bus.br_count, 32'd5);
    chk("release_mispred_count", bus.mispred_count, 32'd4);

    // Randomized traffic; carried predictions mostly come from the model.
    for (int n = 0; n < 3000; n++) begin
      bit          pt;
      int unsigned pc;
      int unsigned tgt;
      cyc();
      bus.if_pc = pick_pc();
      pc = pick_pc();
      model_lookup(pc, pt, tgt);
      if ($urandom_range(0, 9) < 3) begin
        pt  = $urandom_range(0, 1);
        tgt = $urandom_range(0, 3) << 9;
      end
      set_ex($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, pc,
             $urandom_range(0, 1), 32'h1000 + ($urandom_range(0, 3) << 9), pt, tgt);
    end

    // Train 0x140 hard, then pull reset between edges.
    cyc();
    bus.if_pc = 32'h140;
    set_ex(1, 0, 32'h140, 1, 32'h600, 0, 32'h144);
    cyc();
    cyc();
    set_ex(1, 1, 32'h240, 1, 32'h700, 0, 32'h244);
    #1;
    chk("trained_pred_taken", {31'd0, bus.if_pred_taken}, 32'd1);
    chk("trained_pred_target", bus.if_pred_target, 32'h600);
    rstn = 1'b0;
    #1;
    chk("async_rst_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("async_rst_pred_target", bus.if_pred_target, 32'h144);
    chk("async_rst_br_count", bus.br_count, 32'd0);
    chk("async_rst_mispred_count", bus.mispred_count, 32'd0);
    chk("async_rst_resolve", {31'd0, bus.resolve}, 32'd0);
    repeat (2) cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
